// File: rtl/led_status_sequencer.sv
// led_status_sequencer: arbitrates the common-anode RGB status LED between
// NUM_REQ requesters (index 0 highest priority) and plays an 8-step blink
// pattern, one step per 2^TICK_W clock cycles.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req               per-requester request level
//   req_color         {r,g,b} per requester, requester i at [3i+2:3i]
//   req_mode          pattern select per requester, requester i at [2i+1:2i]
//   grant             one-hot current owner (registered), zero when idle
//   busy              high while a grant is held (registered)
//   led_red/green/blue  active-low LED drive (registered)
//
// Optional feature: define LED_IDLE_HEARTBEAT_EN to run a green heartbeat
// while idle. Without it, all LEDs are off in IDLE.
module led_status_sequencer #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TICK_W  = 22
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [3*NUM_REQ-1:0] req_color,
  input  logic [2*NUM_REQ-1:0] req_mode,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 led_red,
  output logic                 led_green,
  output logic                 led_blue
);

  localparam int unsigned STEP_W = 3;
  localparam int unsigned COL_W  = 3;
  localparam int unsigned MODE_W = 2;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t              state, state_n;
  logic [TICK_W-1:0]   presc;
  logic                tick_c;
  logic [STEP_W-1:0]   step, step_n;
  logic [COL_W-1:0]    color, color_n;
  logic [MODE_W-1:0]   mode, mode_n;
  logic [NUM_REQ-1:0]  grant_n;
  logic [COL_W-1:0]    led_q, led_n_c;

  logic [NUM_REQ-1:0]  win_grant_c;
  logic [COL_W-1:0]    win_color_c;
  logic [MODE_W-1:0]   win_mode_c;
  logic                any_req_c;
  logic                owner_req_c;
  logic [7:0]          pat_c;
  logic [7:0]          hb_pat_c;
  logic                pat_bit_c;
  logic                hb_bit_c;

  // Pattern table, MSB is step 0.
  function automatic logic [7:0] pattern(input logic [MODE_W-1:0] m);
    case (m)
      2'b00:   pattern = 8'b1111_1111;
      2'b01:   pattern = 8'b1111_0000;
      2'b10:   pattern = 8'b1010_0000;
      default: pattern = 8'b1010_1010;
    endcase
  endfunction

  assign tick_c = &presc;

  // Fixed-priority arbiter: scan from low priority up so index 0 wins last.
  always_comb begin
    win_grant_c = '0;
    win_color_c = '0;
    win_mode_c  = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_grant_c    = '0;
        win_grant_c[i] = 1'b1;
        win_color_c    = req_color[3*i +: 3];
        win_mode_c     = req_mode[2*i +: 2];
      end
    end
  end

  assign any_req_c   = |req;
  assign owner_req_c = |(req & grant);

  // State register plus prescaler and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      state <= IDLE;
      grant <= '0;
      busy  <= 1'b0;
      color <= '0;
      mode  <= '0;
      step  <= '0;
      led_q <= 3'b111;
    end else begin
      presc <= presc + TICK_W'(1);
      state <= state_n;
      grant <= grant_n;
      busy  <= |grant_n;
      color <= color_n;
      mode  <= mode_n;
      step  <= step_n;
      led_q <= led_n_c;
    end
  end

  // Next-state logic; everything moves only on tick.
  always_comb begin
    state_n = state;
    grant_n = grant;
    color_n = color;
    mode_n  = mode;
    step_n  = step;
    if (tick_c) begin
      case (state)
        IDLE: begin
          if (any_req_c) begin
            state_n = ACTIVE;
            grant_n = win_grant_c;
            color_n = win_color_c;
            mode_n  = win_mode_c;
            step_n  = '0;
          end else begin
`ifdef LED_IDLE_HEARTBEAT_EN
            step_n = step + STEP_W'(1);
`else
            step_n = '0;
`endif
          end
        end
        default: begin
          if (!owner_req_c) begin
            // Owner released: hand over to the best remaining requester.
            step_n = '0;
            if (any_req_c) begin
              grant_n = win_grant_c;
              color_n = win_color_c;
              mode_n  = win_mode_c;
            end else begin
              state_n = IDLE;
              grant_n = '0;
            end
          end else if (step == STEP_W'(7)) begin
            // Pattern wrap is the only preemption point.
            grant_n = win_grant_c;
            color_n = win_color_c;
            mode_n  = win_mode_c;
            step_n  = '0;
          end else begin
            step_n = step + STEP_W'(1);
          end
        end
      endcase
    end
  end

  // LED drive computed from the latched state; registered above.
  assign pat_c     = pattern(mode);
  assign hb_pat_c  = pattern(2'b10);
  assign pat_bit_c = pat_c[~step];
  assign hb_bit_c  = hb_pat_c[~step];

  always_comb begin
    led_n_c = 3'b111;
    if (state == ACTIVE) begin
      led_n_c = ~(color & {COL_W{pat_bit_c}});
    end else begin
`ifdef LED_IDLE_HEARTBEAT_EN
      led_n_c[1] = ~hb_bit_c;
`else
      led_n_c = 3'b111;
`endif
    end
  end

  assign led_red   = led_q[2];
  assign led_green = led_q[1];
  assign led_blue  = led_q[0];

endmodule

// File: tb/tb_led_status_sequencer.sv
// Directed bench for led_status_sequencer with TICK_W=2 (tick every 4 cycles).
// A tick edge is every 4th posedge after reset release; the bench tracks
// the posedge count in cyc and samples on the negedge.
module tb_led_status_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] req_color;
  logic [7:0]  req_mode;
  logic [3:0]  grant;
  logic        busy;
  logic        led_red, led_green, led_blue;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  led_status_sequencer #(.NUM_REQ(4), .TICK_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_color (req_color),
    .req_mode  (req_mode),
    .grant     (grant),
    .busy      (busy),
    .led_red   (led_red),
    .led_green (led_green),
    .led_blue  (led_blue)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic until_cyc(input int c);
    if (c > cyc) cycles(c - cyc);
  endtask

  function automatic logic [31:0] leds();
    return {29'd0, led_red, led_green, led_blue};
  endfunction

  initial begin
    logic [2:0] exp_led;
    rst_n     = 1'b0;
    req       = 4'b0000;
    req_color = 12'h000;
    req_mode  = 8'h00;
    repeat (2) @(negedge clk);
    chk("por_grant", 32'(grant), 32'h0);
    chk("por_busy", 32'(busy), 32'h0);
    chk("por_leds", leds(), 32'h7);
    rst_n = 1'b1;
    cyc   = 0;

    // Idle with no requests: 32 cycles of idle LED behaviour.
    for (int k = 1; k <= 32; k++) begin
      until_cyc(k);
`ifdef LED_IDLE_HEARTBEAT_EN
      exp_led = ((((k - 1) / 4) % 8) == 0 || (((k - 1) / 4) % 8) == 2) ? 3'b101 : 3'b111;
`else
      exp_led = 3'b111;
`endif
      chk("idle_leds", leds(), 32'(exp_led));
      if (k < 4) chk("idle_grant", 32'(grant), 32'h0);
    end

    // Solid blue on requester 2.
    req[2]         = 1'b1;
    req_color[8:6] = 3'b001;
    req_mode[5:4]  = 2'b00;
    until_cyc(36);
    chk("solid_grant", 32'(grant), 32'h4);
    chk("solid_busy", 32'(busy), 32'h1);
    for (int k = 37; k <= 68; k++) begin
      until_cyc(k);
      chk("solid_leds", leds(), 32'h6);
    end

    // Requester 0 rises at step 2 of requester 2's pattern: no preemption.
    until_cyc(76);
    req[0]         = 1'b1;
    req_color[2:0] = 3'b100;
    req_mode[1:0]  = 2'b01;
    for (int t = 80; t <= 96; t += 4) begin
      until_cyc(t);
      chk("nopreempt_grant", 32'(grant), 32'h4);
    end
    until_cyc(100);
    chk("wrap_grant", 32'(grant), 32'h1);

    // Red blink: 16 cycles on, 16 off, repeating.
    for (int k = 101; k <= 148; k++) begin
      until_cyc(k);
      exp_led = ((((k - 101) / 16) % 2) == 0) ? 3'b011 : 3'b111;
      chk("blink_leds", leds(), 32'(exp_led));
    end

    // Owner 0 releases mid-pattern; requester 3 takes over.
    req[0]          = 1'b0;
    req[2]          = 1'b0;
    req[3]          = 1'b1;
    req_color[11:9] = 3'b010;
    req_mode[7:6]   = 2'b00;
    until_cyc(152);
    chk("handover3_grant", 32'(grant), 32'h8);
    until_cyc(153);
    chk("handover3_leds", leds(), 32'h5);

    // Owner 3 drops at step 4 while requester 1 is high.
    until_cyc(168);
    req[3]         = 1'b0;
    req[1]         = 1'b1;
    req_color[5:3] = 3'b111;
    req_mode[3:2]  = 2'b11;
    until_cyc(172);
    chk("handover1_grant", 32'(grant), 32'h2);
    until_cyc(173);
    chk("fast_step0_leds", leds(), 32'h0);
    until_cyc(176);
    req[1] = 1'b0;
    until_cyc(177);
    chk("fast_step1_leds", leds(), 32'h7);
    until_cyc(180);
    chk("release_grant", 32'(grant), 32'h0);
    chk("release_busy", 32'(busy), 32'h0);
    until_cyc(181);
`ifdef LED_IDLE_HEARTBEAT_EN
    chk("release_rb", 32'({led_red, led_blue}), 32'h3);
`else
    chk("release_leds", leds(), 32'h7);
`endif

    // Asynchronous reset mid-pattern with requester 1 active.
    req_mode[3:2] = 2'b00;
    req[1]        = 1'b1;
    until_cyc(184);
    chk("pre_reset_grant", 32'(grant), 32'h2);
    until_cyc(185);
    chk("pre_reset_leds", leds(), 32'h0);
    until_cyc(190);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_leds", leds(), 32'h7);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    for (int k = 1; k <= 3; k++) begin
      until_cyc(k);
      chk("post_rst_grant", 32'(grant), 32'h0);
      chk("post_rst_busy", 32'(busy), 32'h0);
    end
    until_cyc(4);
    chk("post_rst_tick_grant", 32'(grant), 32'h2);
    chk("post_rst_tick_busy", 32'(busy), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
